// File: rtl/slice_pack_pkg.sv
// Shared types and default geometry for the word-to-wide-word packer.
package slice_pack_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  localparam int WIDE_WIDTH_DEF = 320;
  localparam int WORD_WIDTH_DEF = 32;
  localparam int NUM_WORDS      = WIDE_WIDTH_DEF / WORD_WIDTH_DEF;
  localparam int IDX_W          = $clog2(NUM_WORDS);

  // The wide word must split into a whole number of slices, at least two of them.
  function automatic bit geometry_ok(input int wide, input int word);
    return (word > 0) && (wide % word == 0) && (wide / word >= 2);
  endfunction

endpackage

// File: rtl/slice_pack.sv
// Packs a stream of WORD_WIDTH-bit words into one WIDE_WIDTH-bit word.
// Word k lands in bits [WORD_WIDTH*k +: WORD_WIDTH]; unwritten slices read as zero.
module slice_pack
  import slice_pack_pkg::*;
#(
  parameter int  WIDE_WIDTH = WIDE_WIDTH_DEF,
  parameter int  WORD_WIDTH = WORD_WIDTH_DEF,
  localparam int N_SLICES   = WIDE_WIDTH / WORD_WIDTH,
  localparam int SIW        = $clog2(N_SLICES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_word,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDE_WIDTH-1:0] out_data,
  output logic [SIW:0]          out_count
);

  if (!geometry_ok(WIDE_WIDTH, WORD_WIDTH)) begin : g_bad_geometry
    $error("slice_pack: WIDE_WIDTH must be a multiple of WORD_WIDTH with at least two slices");
  end

  pack_state_t           state_q, state_d;
  logic [SIW-1:0]        idx_q, idx_d;
  logic [WIDE_WIDTH-1:0] buf_q, buf_d;
  logic [SIW:0]          count_q, count_d;

  // Next-state logic: fill slices on input handshakes, release on output handshake.
  always_comb begin
    // NOTE: every target gets a default before any branch, so no path leaves a
    // signal unassigned and no latch is inferred; blocking '=' is right here.
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    count_d   = count_q;
    in_ready  = (state_q == FILL);
    out_valid = (state_q == HOLD);

    case (state_q)
      FILL: begin
        if (in_valid) begin
          for (int k = 0; k < N_SLICES; k++) begin
            if (idx_q == SIW'(k)) buf_d[k*WORD_WIDTH +: WORD_WIDTH] = in_word;
          end
          if (in_last || idx_q == SIW'(N_SLICES - 1)) begin
            state_d = HOLD;
            count_d = (SIW+1)'(idx_q) + (SIW+1)'(1);
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + SIW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          buf_d   = '0;
          count_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State register: FSM, slice index, assembly buffer and word count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      // NOTE: the buffer is a plain register, not a RAM, and must be reset:
      // zero padding of short packets relies on it starting cleared.
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking '<=' so every flop samples the pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  assign out_data  = buf_q;
  assign out_count = count_q;

endmodule

// File: doc/slice_pack.md
Name: slice_pack

Overview:
- Inverse of the wide-word slice selector: assembles a stream of WORD_WIDTH-bit words into one WIDE_WIDTH-bit word.
- Word k is written to bits [WORD_WIDTH*k +: WORD_WIDTH], so the selector with index k reads word k back out.
- Sits between a 32-bit bus/host interface and the 320-bit permutation state datapath.
- Valid/ready handshake on both sides; early termination with zero padding.

Parameters:
WIDE_WIDTH, 320, width of the assembled output word; must be an integer multiple of WORD_WIDTH
WORD_WIDTH, 32, width of each input word
NUM_WORDS, WIDE_WIDTH/WORD_WIDTH (10), number of slices; derived, must be >= 2
IDX_W, $clog2(NUM_WORDS), slice index width; derived

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_word is valid
in_ready  output  1  packer can accept a word
in_word  input  WORD_WIDTH  word to insert at the current slice index
in_last  input  1  qualified by in_valid; this word ends the packet
out_valid  output  1  out_data holds a complete packet
out_ready  input  1  consumer accepts out_data
out_data  output  WIDE_WIDTH  assembled word; word 0 is in the LSBs
out_count  output  IDX_W+1  number of words written into out_data (1..NUM_WORDS)

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=FILL, idx=0, buffer=0.
  - out_valid=0, out_data=0, out_count=0; in_ready=1 on the first cycle after release.
- State FILL:
  - in_ready=1, out_valid=0.
  - Input handshake is in_valid & in_ready. On a handshake, buffer[WORD_WIDTH*idx +: WORD_WIDTH] <= in_word.
  - If idx==NUM_WORDS-1 or in_last=1: go to HOLD; out_count <= idx+1; idx <= 0.
  - Otherwise idx <= idx+1.
  - With no handshake, all state holds.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_data=buffer, stable until out_ready=1.
  - On out_ready=1: go to FILL; buffer <= 0; out_count <= 0.
- Padding: slices never written in a packet read as 0, because the buffer is cleared on every HOLD->FILL transition and at reset.
- Latency and throughput:
  - out_valid rises the cycle after the final input handshake.
  - Each out_ready handshake costs one bubble cycle.
  - Full packet throughput: NUM_WORDS+1 cycles per packet when out_ready is held at 1.
- in_ready is a function of state only. It has no combinational path from out_ready or in_valid.
- Boundary cases:
  - in_last on the NUM_WORDS-th word: treated the same as a full packet, out_count=NUM_WORDS.
  - in_last on the first word: out_count=1.
  - idx never exceeds NUM_WORDS-1; wrap goes only to 0, via HOLD.
  - in_valid while in HOLD: ignored; the word is not consumed because in_ready=0.
  - in_last while in_valid=0: ignored.
  - Reset mid-FILL or mid-HOLD: partial or pending packet discarded, outputs return to reset values immediately.

Decomposition:
- Shared package holds:
  - pack_state_t enum {FILL, HOLD}.
  - Localparams NUM_WORDS and IDX_W, with an elaboration-time assertion that WIDE_WIDTH % WORD_WIDTH == 0 and NUM_WORDS >= 2.
- No sub-module. The FSM, index counter and buffer are one always_ff plus one always_comb.
- The bench instantiates the existing slice selector for readback checks.

Test Plan:
- Full packet: WIDE=320, WORD=32. Send words 0xA0000000+k for k=0..9 back-to-back, out_ready=1.
  -> out_valid=1 exactly one cycle after the 10th handshake.
  -> out_data[32k+:32]=0xA0000000+k; out_count=10.
  -> in_ready=0 for that one cycle only.
- Early last: send 0x11111111, 0x22222222, 0x33333333, then 0x44444444 with in_last=1.
  -> out_count=4; out_data[127:0]=0x44444444_33333333_22222222_11111111; out_data[319:128]=0.
- Backpressure: complete a packet, hold out_ready=0 for 5 cycles while driving in_valid=1 with 0xDEADBEEF.
  -> out_data and out_count stable; in_ready=0.
  -> 0xDEADBEEF is accepted as word 0 of the next packet only after out_ready=1 plus one cycle.
- Reset mid-fill: accept 4 words, assert reset for 1 cycle, then send one word 0x5 with in_last=1.
  -> out_count=1; out_data=0x5 zero-extended; no residue from the earlier words.
- Single-word packet followed by a full packet: first output is out_count=1; second is out_count=10.
  -> Slices 1..9 of the first output are 0.
  -> Second output contains only new data.
- Round trip: random 10-word packet, then the selector with index 0..9 applied to out_data.
  -> Each slice equals the input word sent at that position.
  -> With the selector's reset=1, its output is 0.
